// File: rtl/aes_ctr_sched.sv
// aes_ctr_sched: owns the 128-bit CTR counter and grants one block per request.
// It arbitrates counter access between software IV writes and the slice-serial
// increment FSM, tracks a block budget and locks up on protocol errors.
// Ports:
//   clk_i, rst_ni (async, active-low)
//   iv_we_i, iv_wdata_i, clear_i     software IV load / clear
//   blk_req_i, blk_ack_o, ctr_o      block grant handshake and counter value
//   num_blks_i, budget_done_o        block budget (0 = unlimited)
//   busy_o, incr_o                   increment status / request to the FSM
//   fsm_ready_i, fsm_alert_i         increment FSM status
//   fsm_slice_idx_i, fsm_slice_o     slice read port for the FSM
//   fsm_slice_i, fsm_we_i            slice write port from the FSM
//   err_o, ctr_wrap_o                sticky error / sticky wrap flag
// Option macro: AES_CTR_SCHED_WRAP_STOP_EN blocks grants after a counter wrap.
module aes_ctr_sched #(
  parameter int unsigned SliceSize = 16,
  parameter int unsigned NumSlices = 8,
  parameter int unsigned SliceIdxW = 3,
  parameter int unsigned BlkCntW   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumSlices-1:0]           iv_we_i,
  input  logic [SliceSize*NumSlices-1:0] iv_wdata_i,
  input  logic                           clear_i,
  input  logic                           blk_req_i,
  output logic                           blk_ack_o,
  output logic [SliceSize*NumSlices-1:0] ctr_o,
  input  logic [BlkCntW-1:0]             num_blks_i,
  output logic                           budget_done_o,
  output logic                           busy_o,
  output logic                           incr_o,
  input  logic                           fsm_ready_i,
  input  logic                           fsm_alert_i,
  input  logic [SliceIdxW-1:0]           fsm_slice_idx_i,
  output logic [SliceSize-1:0]           fsm_slice_o,
  input  logic [SliceSize-1:0]           fsm_slice_i,
  input  logic                           fsm_we_i,
  output logic                           err_o,
  output logic                           ctr_wrap_o
);

  localparam int unsigned CntW = SliceIdxW + 1;
  localparam logic [CntW-1:0] NumSlicesC = CntW'(NumSlices);

  typedef enum logic [1:0] {
    Idle  = 2'b00,
    Busy  = 2'b01,
    Error = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic [NumSlices-1:0][SliceSize-1:0] ctr_q, ctr_d;
  logic [BlkCntW-1:0] blk_cnt_q, blk_cnt_d;
  logic [CntW-1:0]    exp_idx_q, exp_idx_d;
  logic               clr_pend_q, clr_pend_d;
  logic               wrap_q;

  logic            in_idle, in_busy;
  logic            iv_any, clr_eff;
  logic [CntW-1:0] wr_cnt;
  logic            idx_bad, early_rdy;
  logic            idle_err, busy_err;
  logic            busy_exit, grant;

  assign in_idle = (state_q == Idle);
  assign in_busy = (state_q == Busy);

  assign iv_any  = |iv_we_i;
  // A clear deferred from BUSY takes effect like a fresh clear_i.
  assign clr_eff = clear_i | clr_pend_q;

  // Write count including the write happening this cycle.
  assign wr_cnt = exp_idx_q + CntW'(fsm_we_i);

  assign idx_bad   = fsm_we_i &&
                     ({1'b0, fsm_slice_idx_i} != exp_idx_q);
  assign early_rdy = fsm_ready_i && (wr_cnt < NumSlicesC);

  assign idle_err = in_idle && (fsm_alert_i || fsm_we_i);
  assign busy_err = in_busy &&
                    (fsm_alert_i || idx_bad || early_rdy);

  assign busy_exit = in_busy && !busy_err && fsm_ready_i;

  assign budget_done_o = (num_blks_i != '0) &&
                         (blk_cnt_q >= num_blks_i);

  assign grant = in_idle && !idle_err &&
                 blk_req_i && fsm_ready_i &&
                 !budget_done_o && !iv_any &&
                 !clr_eff && !wrap_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      in_idle: begin
        if (idle_err) begin
          state_d = Error;
        end else if (grant) begin
          state_d = Busy;
        end
      end
      in_busy: begin
        if (busy_err) begin
          state_d = Error;
        end else if (busy_exit) begin
          state_d = Idle;
        end
      end
      default: state_d = Error;
    endcase
  end

  // busy_o covers the grant cycle so it spans the whole increment.
  always_comb begin
    blk_ack_o = 1'b0;
    incr_o    = 1'b0;
    busy_o    = 1'b0;
    err_o     = 1'b0;
    unique case (1'b1)
      in_idle: begin
        blk_ack_o = grant;
        incr_o    = grant;
        busy_o    = grant;
      end
      in_busy: busy_o = 1'b1;
      default: err_o = 1'b1;
    endcase
  end

  always_comb begin
    ctr_d      = ctr_q;
    blk_cnt_d  = blk_cnt_q;
    exp_idx_d  = exp_idx_q;
    clr_pend_d = clr_pend_q;
    if (in_idle && !idle_err) begin
      if (clr_eff) begin
        ctr_d      = '0;
        blk_cnt_d  = '0;
        clr_pend_d = 1'b0;
      end else if (iv_any) begin
        for (int unsigned i = 0; i < NumSlices; i++) begin
          if (iv_we_i[i]) begin
            ctr_d[i] = iv_wdata_i[i*SliceSize +: SliceSize];
          end
        end
      end else if (grant) begin
        exp_idx_d = '0;
        if (!(&blk_cnt_q)) begin
          blk_cnt_d = blk_cnt_q + BlkCntW'(1);
        end
      end
    end
    if (in_busy && !busy_err) begin
      if (fsm_we_i) begin
        ctr_d[fsm_slice_idx_i] = fsm_slice_i;
        exp_idx_d = wr_cnt;
      end
      if (clear_i) begin
        clr_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctr_q      <= '0;
      blk_cnt_q  <= '0;
      exp_idx_q  <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      ctr_q      <= ctr_d;
      blk_cnt_q  <= blk_cnt_d;
      exp_idx_q  <= exp_idx_d;
      clr_pend_q <= clr_pend_d;
    end
  end

`ifdef AES_CTR_SCHED_WRAP_STOP_EN
  logic wrap_set, wrap_clr;

  // Wrap is judged on the value the increment leaves behind.
  assign wrap_set = busy_exit && (ctr_d == '0);
  assign wrap_clr = in_idle && !idle_err &&
                    (clr_eff || iv_any);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_q <= 1'b0;
    end else if (wrap_clr) begin
      wrap_q <= 1'b0;
    end else if (wrap_set) begin
      wrap_q <= 1'b1;
    end
  end
`else
  assign wrap_q = 1'b0;
`endif

  assign ctr_wrap_o  = wrap_q;
  assign ctr_o       = ctr_q;
  assign fsm_slice_o = ctr_q[fsm_slice_idx_i];

endmodule

// File: tb/tb_aes_ctr_sched.sv
// tb_aes_ctr_sched: directed + randomized bench for aes_ctr_sched.
// Drives a model increment FSM and checks against a 128-bit arithmetic model.
module tb_aes_ctr_sched;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [7:0]   iv_we_i;
  logic [127:0] iv_wdata_i;
  logic         clear_i;
  logic         blk_req_i;
  logic         blk_ack_o;
  logic [127:0] ctr_o;
  logic [15:0]  num_blks_i;
  logic         budget_done_o;
  logic         busy_o;
  logic         incr_o;
  logic         fsm_ready_i;
  logic         fsm_alert_i;
  logic [2:0]   fsm_slice_idx_i;
  logic [15:0]  fsm_slice_o;
  logic [15:0]  fsm_slice_i;
  logic         fsm_we_i;
  logic         err_o;
  logic         ctr_wrap_o;

  aes_ctr_sched dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .iv_we_i         (iv_we_i),
    .iv_wdata_i      (iv_wdata_i),
    .clear_i         (clear_i),
    .blk_req_i       (blk_req_i),
    .blk_ack_o       (blk_ack_o),
    .ctr_o           (ctr_o),
    .num_blks_i      (num_blks_i),
    .budget_done_o   (budget_done_o),
    .busy_o          (busy_o),
    .incr_o          (incr_o),
    .fsm_ready_i     (fsm_ready_i),
    .fsm_alert_i     (fsm_alert_i),
    .fsm_slice_idx_i (fsm_slice_idx_i),
    .fsm_slice_o     (fsm_slice_o),
    .fsm_slice_i     (fsm_slice_i),
    .fsm_we_i        (fsm_we_i),
    .err_o           (err_o),
    .ctr_wrap_o      (ctr_wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [127:0] ref_ctr;
  int           ref_cnt;
  bit           ref_wrap;
  bit           ref_pend;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit exp_budget();
    return (num_blks_i != 16'd0) && (ref_cnt >= int'(num_blks_i));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic ref_reset();
    ref_ctr  = '0;
    ref_cnt  = 0;
    ref_wrap = 1'b0;
    ref_pend = 1'b0;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    fsm_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    fsm_alert_i = 1'b0;
    blk_req_i = 1'b0;
    iv_we_i = '0;
    clear_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    ref_reset();
  endtask

  task automatic iv_load(input logic [7:0] mask,
                         input logic [127:0] data);
    iv_we_i = mask;
    iv_wdata_i = data;
    tick();
    iv_we_i = '0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) ref_ctr[i*16 +: 16] = data[i*16 +: 16];
    end
    if (mask != '0) ref_wrap = 1'b0;
    chk("iv_load", ctr_o, ref_ctr);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    ref_ctr = '0;
    ref_cnt = 0;
    ref_wrap = 1'b0;
  endtask

  // One request; when granted, the model FSM runs the ripple increment.
  task automatic try_block(input bit hold, input bit disturb);
    logic [16:0]  sum;
    logic         c;
    bit           g;
    logic [127:0] nxt;
    blk_req_i = 1'b1;
    #1;
    g = !exp_budget() && !ref_wrap;
    chkb("ack", blk_ack_o, g);
    chkb("incr", incr_o, g);
    if (!g) begin
      tick();
      blk_req_i = hold;
    end else begin
      chk("ctr_at_grant", ctr_o, ref_ctr);
      chkb("busy_grant", busy_o, 1'b1);
      nxt = ref_ctr + 128'd1;
      if (ref_cnt < 65535) ref_cnt++;
      tick();
      blk_req_i = hold;
      c = 1'b1;
      for (int k = 0; k < 8; k++) begin
        fsm_we_i = 1'b1;
        fsm_slice_idx_i = 3'(k);
        fsm_ready_i = (k == 7);
        if (disturb && k == 2) begin
          iv_we_i = 8'hFF;
          iv_wdata_i = rnd128();
          clear_i = 1'b1;
          ref_pend = 1'b1;
        end else begin
          iv_we_i = '0;
          clear_i = 1'b0;
        end
        #1;
        chk("slice_rd", 128'(fsm_slice_o), 128'(ref_ctr[k*16 +: 16]));
        sum = {1'b0, fsm_slice_o} + 17'(c);
        fsm_slice_i = sum[15:0];
        c = sum[16];
        chkb("busy_w", busy_o, 1'b1);
        chkb("ack_w", blk_ack_o, 1'b0);
        chkb("incr_w", incr_o, 1'b0);
        tick();
      end
      fsm_we_i = 1'b0;
      fsm_ready_i = 1'b1;
      iv_we_i = '0;
      clear_i = 1'b0;
      ref_ctr = nxt;
`ifdef AES_CTR_SCHED_WRAP_STOP_EN
      if (ref_ctr == '0) ref_wrap = 1'b1;
`endif
      #1;
      chk("ctr_inc", ctr_o, ref_ctr);
      chkb("wrap", ctr_wrap_o, ref_wrap);
      if (!hold) chkb("busy_idle", busy_o, 1'b0);
      if (ref_pend) begin
        tick();
        ref_ctr = '0;
        ref_cnt = 0;
        ref_wrap = 1'b0;
        ref_pend = 1'b0;
        chk("ctr_pend_clr", ctr_o, ref_ctr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] pre, nxt, d;
    logic [16:0]  sum;
    logic         c;
    int           nlow;
    logic [7:0]   m;

    rst_ni = 1'b0;
    iv_we_i = '0;
    iv_wdata_i = '0;
    clear_i = 1'b0;
    blk_req_i = 1'b0;
    num_blks_i = '0;
    fsm_ready_i = 1'b1;
    fsm_alert_i = 1'b0;
    fsm_slice_idx_i = '0;
    fsm_slice_i = '0;
    fsm_we_i = 1'b0;
    ref_reset();
    tick();
    tick();
    chk("rst_ctr", ctr_o, 128'd0);
    chkb("rst_err", err_o, 1'b0);
    chkb("rst_busy", busy_o, 1'b0);
    chkb("rst_ack", blk_ack_o, 1'b0);
    chkb("rst_incr", incr_o, 1'b0);
    chkb("rst_budget", budget_done_o, 1'b0);
    chkb("rst_wrap", ctr_wrap_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // IV = 5, request held: second grant lands on cycle 9.
    iv_load(8'hFF, 128'd5);
    try_block(1'b1, 1'b0);
    try_block(1'b0, 1'b0);

    // Random IVs and partial slice loads, with forced carry chains.
    for (int it = 0; it < 6; it++) begin
      m = 8'($urandom_range(1, 255));
      iv_load(m, rnd128());
      nlow = $urandom_range(0, 7);
      d = '1;
      iv_load(8'((1 << nlow) - 1), d);
      try_block(1'b0, 1'b0);
    end

    // Budget of two blocks.
    do_clear();
    num_blks_i = 16'd2;
    try_block(1'b1, 1'b0);
    try_block(1'b1, 1'b0);
    try_block(1'b0, 1'b0);
    chkb("budget_done", budget_done_o, 1'b1);
    do_clear();
    chkb("budget_clr", budget_done_o, 1'b0);
    chk("ctr_clr", ctr_o, ref_ctr);
    num_blks_i = '0;

    // Wrap from all-ones.
    d = '1;
    iv_load(8'hFF, d);
    try_block(1'b0, 1'b0);
    chk("wrap_zero", ctr_o, 128'd0);
    try_block(1'b0, 1'b0);
    iv_load(8'h01, 128'd9);
    chkb("wrap_cleared", ctr_wrap_o, 1'b0);
    try_block(1'b0, 1'b0);

    // IV write and clear during BUSY.
    iv_load(8'hFF, rnd128());
    try_block(1'b0, 1'b1);

    // Bad slice index sequence 0,1,3.
    iv_load(8'hFF, rnd128());
    pre = ref_ctr;
    nxt = pre + 128'd1;
    blk_req_i = 1'b1;
    #1;
    chkb("err_grant", blk_ack_o, 1'b1);
    tick();
    blk_req_i = 1'b0;
    c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fsm_we_i = 1'b1;
      fsm_ready_i = 1'b0;
      fsm_slice_idx_i = (k == 2) ? 3'd3 : 3'(k);
      #1;
      sum = {1'b0, fsm_slice_o} + 17'(c);
      fsm_slice_i = sum[15:0];
      c = sum[16];
      tick();
    end
    fsm_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    #1;
    chkb("err_set", err_o, 1'b1);
    ref_ctr = {pre[127:32], nxt[31:0]};
    chk("err_frozen", ctr_o, ref_ctr);
    for (int k = 0; k < 3; k++) begin
      blk_req_i = 1'b1;
      iv_we_i = 8'hFF;
      iv_wdata_i = rnd128();
      clear_i = (k == 1);
      #1;
      chkb("err_ack", blk_ack_o, 1'b0);
      chkb("err_incr", incr_o, 1'b0);
      tick();
      chkb("err_sticky", err_o, 1'b1);
      chk("err_ctr", ctr_o, ref_ctr);
    end
    blk_req_i = 1'b0;
    iv_we_i = '0;
    clear_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chkb("err_rst", err_o, 1'b0);
    chk("err_rst_ctr", ctr_o, 128'd0);
    reset_dut();

    // Reset after four slice writes.
    iv_load(8'hFF, rnd128());
    blk_req_i = 1'b1;
    #1;
    chkb("mid_grant", blk_ack_o, 1'b1);
    tick();
    blk_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fsm_we_i = 1'b1;
      fsm_ready_i = 1'b0;
      fsm_slice_idx_i = 3'(k);
      #1;
      fsm_slice_i = fsm_slice_o + 16'd1;
      tick();
    end
    fsm_we_i = 1'b0;
    fsm_ready_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ctr", ctr_o, 128'd0);
    chkb("mid_rst_busy", busy_o, 1'b0);
    chkb("mid_rst_err", err_o, 1'b0);
    reset_dut();
    try_block(1'b0, 1'b0);
    chk("fresh_blk", ctr_o, 128'd1);

    // Alert from the FSM.
    fsm_alert_i = 1'b1;
    tick();
    fsm_alert_i = 1'b0;
    chkb("alert_err", err_o, 1'b1);
    reset_dut();
    chkb("alert_rst", err_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
